// File: rtl/ureg_n.sv
// Universal WIDTH-bit register: hold, load, shift, rotate, count up/down and
// synchronous clear, selected by a 3-bit mode; asynchronous active-low reset.
module ureg_n #(
  parameter int unsigned WIDTH     = 16,
  parameter logic [63:0] RESET_VAL = 64'd0
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RST_Q = RESET_VAL[WIDTH-1:0];

  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_LOAD  = 3'b001,
    M_SHL   = 3'b010,
    M_SHR   = 3'b011,
    M_INC   = 3'b100,
    M_DEC   = 3'b101,
    M_CLR   = 3'b110,
    M_ROL   = 3'b111
  } mode_e;

  mode_e            mode_w;
  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             tc_w;

  assign mode_w = mode_e'(mode);

  function automatic logic [WIDTH-1:0] next_val(
    input mode_e            m,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] din,
    input logic             si
  );
    logic [WIDTH-1:0] nv;
    nv = cur;
    case (m)
      M_HOLD: nv = cur;
      M_LOAD: nv = din;
      M_SHL:  nv = {cur[WIDTH-2:0], si};
      M_SHR:  nv = {si, cur[WIDTH-1:1]};
      M_INC:  nv = cur + {{(WIDTH-1){1'b0}}, 1'b1};
      M_DEC:  nv = cur - {{(WIDTH-1){1'b0}}, 1'b1};
      M_CLR:  nv = '0;
      M_ROL:  nv = {cur[WIDTH-2:0], cur[WIDTH-1]};
      default: nv = cur;
    endcase
    return nv;
  endfunction

  // tc ignores en so a chain can use it as a look-ahead carry.
  always_comb begin
    tc_w = 1'b0;
    if (mode_w == M_INC)      tc_w = &q_q;
    else if (mode_w == M_DEC) tc_w = ~|q_q;
  end

  always_comb begin
    sout = 1'b0;
    case (mode_w)
      M_SHL, M_ROL: sout = q_q[WIDTH-1];
      M_SHR:        sout = q_q[0];
      default:      sout = 1'b0;
    endcase
  end

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (en) begin
      q_d    = next_val(mode_w, q_q, d, sin);
      wrap_d = tc_w;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      q_q    <= RST_Q;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign tc   = tc_w;
  assign wrap = wrap_q;

endmodule
